// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: next-PC generation, branch redirect and a BUF_DEPTH-entry instruction buffer.
// Optional macro IF_ADEF_CHECK_EN: misaligned redirect targets raise an address-error entry and halt fetch.
module if_fetch_buf #(
   parameter logic [31:0] RESET_PC  = 32'h1c000000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ID_allow_in,
   output logic        IF_to_ID_valid,
   output logic [63:0] to_ID_data,
   output logic        IF_excp_adef
);

   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OW = CW + 1;
   localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [OW-1:0] DEPTH_W    = OW'(BUF_DEPTH);
   localparam logic [PW-1:0] LAST_PTR   = PW'(BUF_DEPTH - 1);
   localparam logic [31:0]   ALIGN_MASK = 32'hffff_fffc;

   logic [31:0]   fpc;
   logic          pend;
   logic [31:0]   pend_pc;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   mem_pc   [BUF_DEPTH];
   logic [31:0]   mem_inst [BUF_DEPTH];

   logic [31:0]   tgt;
   logic          tgt_adef;
   logic          pop;
   logic          push;
   logic [31:0]   push_inst;
   logic [OW-1:0] occ;
   logic          issue;

`ifdef IF_ADEF_CHECK_EN
   logic          pend_adef;
   logic          halt;
   logic          mem_adef [BUF_DEPTH];
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // redirect target qualification
`ifdef IF_ADEF_CHECK_EN
   assign tgt       = br_target;
   assign tgt_adef  = (br_target[1:0] != 2'b00);
   assign push_inst = pend_adef ? 32'h0 : inst_sram_rdata;
`else
   assign tgt       = br_target & ALIGN_MASK;
   assign tgt_adef  = 1'b0;
   assign push_inst = inst_sram_rdata;
`endif

   // handshake and credit: the in-flight request always holds a slot
   assign IF_to_ID_valid = ~reset & (count != '0);
   assign pop            = IF_to_ID_valid & ID_allow_in & ~br_taken;
   assign push           = pend & ~br_taken;
   assign occ            = OW'(count) + OW'(pend) - OW'(pop);
`ifdef IF_ADEF_CHECK_EN
   assign issue          = ~halt & (occ < DEPTH_W);
`else
   assign issue          = (occ < DEPTH_W);
`endif

   assign inst_sram_en    = ~reset & (br_taken ? ~tgt_adef : issue);
   assign inst_sram_addr  = br_taken ? tgt : fpc;
   assign inst_sram_we    = 4'b0;
   assign inst_sram_wdata = 32'b0;

   assign to_ID_data = {mem_pc[rd_ptr], mem_inst[rd_ptr]};
`ifdef IF_ADEF_CHECK_EN
   assign IF_excp_adef = IF_to_ID_valid & mem_adef[rd_ptr];
`else
   assign IF_excp_adef = 1'b0;
`endif

   // fetch PC, pending request and FIFO bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         fpc     <= RESET_PC;
         pend    <= 1'b0;
         pend_pc <= RESET_PC;
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else if (br_taken) begin
         fpc     <= tgt + 32'd4;
         pend    <= 1'b1;
         pend_pc <= tgt;
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         count <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (issue) begin
            fpc     <= fpc + 32'd4;
            pend    <= 1'b1;
            pend_pc <= fpc;
         end else begin
            pend    <= 1'b0;
         end
      end
   end

`ifdef IF_ADEF_CHECK_EN
   // address-error tracking: a misaligned redirect halts fetch until the next redirect
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_adef <= 1'b0;
         halt      <= 1'b0;
      end else if (br_taken) begin
         pend_adef <= tgt_adef;
         halt      <= tgt_adef;
      end else if (issue) begin
         pend_adef <= 1'b0;
      end
   end
`endif

   // buffer storage, written at the tail when a return lands
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_pc[wr_ptr]   <= pend_pc;
         mem_inst[wr_ptr] <= push_inst;
`ifdef IF_ADEF_CHECK_EN
         mem_adef[wr_ptr] <= pend_adef;
`endif
      end
   end

endmodule
